// File: rtl/axis_stream_receiver.sv
`default_nettype none
// ============================================================================
// Module   : axis_stream_receiver
// Purpose  : AXI4-Stream slave. Accepted beats are buffered in a FIFO and
//            forwarded bit-exact on a valid/ready output toward the I2S
//            transmit datapath. Every accepted beat is checked for sparse
//            non-last beats, TSTRB/TKEEP consistency and ID/DEST
//            interleaving, and packet statistics are kept.
// Ports    : ACLK, ARESETn (async, active-low)
//            T* slave side   : TVALID/TREADY, TDATA, TSTRB, TKEEP, TLAST,
//                              TID, TDEST, TUSER
//            out_* side      : out_valid/out_ready plus the FIFO head fields
//            status          : fifo_level, pkt_count, last_pkt_bytes,
//                              err_sparse, err_keep_strb, err_interleave,
//                              clear_status (synchronous clear)
// Revision : 1.0 - initial release
// ============================================================================
module axis_stream_receiver #(
  parameter int DATA_BUS_WIDTH  = 32,
  parameter int ID_BUS_WIDTH    = 8,
  parameter int DEST_BUS_WIDTH  = 4,
  parameter int USER_BUS_WIDTH  = 8,
  parameter int FIFO_DEPTH      = 8,
  parameter int STROBE_NOT_USED = 0,
  parameter int KEEP_NOT_USED   = 0
) (
  input  logic                            ACLK,
  input  logic                            ARESETn,
  input  logic                            TVALID,
  output logic                            TREADY,
  input  logic [DATA_BUS_WIDTH-1:0]       TDATA,
  input  logic [DATA_BUS_WIDTH/8-1:0]     TSTRB,
  input  logic [DATA_BUS_WIDTH/8-1:0]     TKEEP,
  input  logic                            TLAST,
  input  logic [ID_BUS_WIDTH-1:0]         TID,
  input  logic [DEST_BUS_WIDTH-1:0]       TDEST,
  input  logic [USER_BUS_WIDTH-1:0]       TUSER,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_BUS_WIDTH-1:0]       out_data,
  output logic [DATA_BUS_WIDTH/8-1:0]     out_strb,
  output logic [DATA_BUS_WIDTH/8-1:0]     out_keep,
  output logic                            out_last,
  output logic [ID_BUS_WIDTH-1:0]         out_id,
  output logic [DEST_BUS_WIDTH-1:0]       out_dest,
  output logic [USER_BUS_WIDTH-1:0]       out_user,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic [15:0]                     pkt_count,
  output logic [15:0]                     last_pkt_bytes,
  output logic                            err_sparse,
  output logic                            err_keep_strb,
  output logic                            err_interleave,
  input  logic                            clear_status
);

  localparam int c_SW    = DATA_BUS_WIDTH / 8;
  localparam int c_AW    = $clog2(FIFO_DEPTH);
  localparam int c_LW    = c_AW + 1;
  localparam int c_CW    = $clog2(c_SW) + 1;
  localparam int c_REC_W = DATA_BUS_WIDTH + 2 * c_SW + 1 + ID_BUS_WIDTH
                         + DEST_BUS_WIDTH + USER_BUS_WIDTH;
  localparam logic [c_LW-1:0] c_DEPTH = c_LW'(FIFO_DEPTH);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_IN_PKT = 1'b1;

  // --------------------------------------------------------------------------
  // Handshakes and FIFO bookkeeping
  // --------------------------------------------------------------------------
  logic                  r_tready;
  logic [c_AW-1:0]       r_wr_ptr;
  logic [c_AW-1:0]       r_rd_ptr;
  logic [c_LW-1:0]       r_level;
  logic [c_REC_W-1:0]    r_mem [FIFO_DEPTH];

  logic                  w_push;
  logic                  w_pop;
  logic [c_LW-1:0]       w_level_next;
  logic [c_REC_W-1:0]    w_rec;
  logic [c_REC_W-1:0]    w_head;

  assign w_push    = TVALID & r_tready;
  assign out_valid = (r_level != '0);
  assign w_pop     = out_valid & out_ready;

  always_comb begin
    w_level_next = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_next = r_level + c_LW'(1);
      2'b01:   w_level_next = r_level - c_LW'(1);
      default: w_level_next = r_level;
    endcase
  end

  // TREADY looks only at the post-edge level, so a pop while full does not
  // reopen the slave until the following edge (no full-bypass path).
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_tready <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      r_tready <= (w_level_next < c_DEPTH);
      r_level  <= w_level_next;
      if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
    end
  end

  assign w_rec = {TDATA, TSTRB, TKEEP, TLAST, TID, TDEST, TUSER};

  // Storage needs no reset: the head is masked to zero whenever the FIFO is
  // empty, which also covers the post-reset state.
  always_ff @(posedge ACLK) begin
    if (w_push) r_mem[r_wr_ptr] <= w_rec;
  end

  assign w_head = out_valid ? r_mem[r_rd_ptr] : '0;
  assign {out_data, out_strb, out_keep, out_last, out_id, out_dest, out_user} = w_head;

  assign TREADY     = r_tready;
  assign fifo_level = r_level;

  // --------------------------------------------------------------------------
  // Protocol checks and packet statistics
  // --------------------------------------------------------------------------
  logic [0:0]                r_state;
  logic [ID_BUS_WIDTH-1:0]   r_id;
  logic [DEST_BUS_WIDTH-1:0] r_dest;
  logic [15:0]               r_acc;
  logic [15:0]               r_pkt_count;
  logic [15:0]               r_last_bytes;
  logic                      r_err_sparse;
  logic                      r_err_keep_strb;
  logic                      r_err_interleave;

  logic [c_SW-1:0]           w_keep_eff;
  logic [c_CW-1:0]           w_keep_cnt;
  logic [16:0]               w_sum;
  logic [15:0]               w_sum_sat;
  logic [15:0]               w_pc_inc;
  logic                      w_ev_sparse;
  logic                      w_ev_keep_strb;
  logic                      w_ev_interleave;

  assign w_keep_eff = (KEEP_NOT_USED != 0) ? {c_SW{1'b1}} : TKEEP;

  always_comb begin
    w_keep_cnt = '0;
    for (int i = 0; i < c_SW; i++) begin
      w_keep_cnt = w_keep_cnt + {{(c_CW-1){1'b0}}, w_keep_eff[i]};
    end
  end

  assign w_sum     = {1'b0, r_acc} + 17'(w_keep_cnt);
  assign w_sum_sat = w_sum[16] ? 16'hFFFF : w_sum[15:0];
  assign w_pc_inc  = (r_pkt_count == 16'hFFFF) ? r_pkt_count : r_pkt_count + 16'd1;

  assign w_ev_sparse     = (KEEP_NOT_USED == 0) && !TLAST && (TKEEP != {c_SW{1'b1}});
  assign w_ev_keep_strb  = (KEEP_NOT_USED == 0) && (STROBE_NOT_USED == 0)
                         && ((TSTRB & ~TKEEP) != '0);
  assign w_ev_interleave = (r_state == S_IN_PKT) && ((TID != r_id) || (TDEST != r_dest));

  // Packet framing and byte accumulation; clear_status leaves the running
  // accumulator alone so a packet in flight still reports its full size.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state <= S_IDLE;
      r_id    <= '0;
      r_dest  <= '0;
      r_acc   <= '0;
    end else if (w_push) begin
      r_acc <= TLAST ? 16'd0 : w_sum_sat;
      case (r_state)
        S_IDLE: begin
          r_id   <= TID;
          r_dest <= TDEST;
          if (!TLAST) r_state <= S_IN_PKT;
        end
        default: begin
          if (TLAST) r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Clear is applied first; a same-cycle event then overrides it.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_pkt_count      <= '0;
      r_last_bytes     <= '0;
      r_err_sparse     <= 1'b0;
      r_err_keep_strb  <= 1'b0;
      r_err_interleave <= 1'b0;
    end else begin
      if (clear_status) begin
        r_pkt_count      <= '0;
        r_last_bytes     <= '0;
        r_err_sparse     <= 1'b0;
        r_err_keep_strb  <= 1'b0;
        r_err_interleave <= 1'b0;
      end
      if (w_push) begin
        if (TLAST) begin
          r_pkt_count  <= clear_status ? 16'd1 : w_pc_inc;
          r_last_bytes <= w_sum_sat;
        end
        if (w_ev_sparse)     r_err_sparse     <= 1'b1;
        if (w_ev_keep_strb)  r_err_keep_strb  <= 1'b1;
        if (w_ev_interleave) r_err_interleave <= 1'b1;
      end
    end
  end

  assign pkt_count      = r_pkt_count;
  assign last_pkt_bytes = r_last_bytes;
  assign err_sparse     = r_err_sparse;
  assign err_keep_strb  = r_err_keep_strb;
  assign err_interleave = r_err_interleave;

endmodule
`default_nettype wire

// File: tb/tb_axis_stream_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_stream_receiver
// Purpose  : Self-checking bench for axis_stream_receiver (32-bit data,
//            depth 8). A vector table drives single beats and checks the
//            status outputs after each; a scoreboard queue holds every
//            accepted beat and compares it when it leaves on out_*.
//            Hand-written sequences cover backpressure and reset mid-packet.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_stream_receiver;

  logic        ACLK;
  logic        ARESETn;
  logic        TVALID;
  logic        TREADY;
  logic [31:0] TDATA;
  logic [3:0]  TSTRB;
  logic [3:0]  TKEEP;
  logic        TLAST;
  logic [7:0]  TID;
  logic [3:0]  TDEST;
  logic [7:0]  TUSER;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_strb;
  logic [3:0]  out_keep;
  logic        out_last;
  logic [7:0]  out_id;
  logic [3:0]  out_dest;
  logic [7:0]  out_user;
  logic [3:0]  fifo_level;
  logic [15:0] pkt_count;
  logic [15:0] last_pkt_bytes;
  logic        err_sparse;
  logic        err_keep_strb;
  logic        err_interleave;
  logic        clear_status;

  axis_stream_receiver dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .TVALID(TVALID), .TREADY(TREADY), .TDATA(TDATA), .TSTRB(TSTRB),
    .TKEEP(TKEEP), .TLAST(TLAST), .TID(TID), .TDEST(TDEST), .TUSER(TUSER),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_strb(out_strb), .out_keep(out_keep), .out_last(out_last),
    .out_id(out_id), .out_dest(out_dest), .out_user(out_user),
    .fifo_level(fifo_level), .pkt_count(pkt_count),
    .last_pkt_bytes(last_pkt_bytes), .err_sparse(err_sparse),
    .err_keep_strb(err_keep_strb), .err_interleave(err_interleave),
    .clear_status(clear_status)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit chk_lat = 1'b0;

  always @(posedge ACLK) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- scoreboard
  typedef struct {
    logic [31:0] data;
    logic [3:0]  strb;
    logic [3:0]  keep;
    logic        last;
    logic [7:0]  id;
    logic [3:0]  dest;
    logic [7:0]  user;
    int          cyc;
  } beat_t;

  beat_t sb[$];

  // Inputs and outputs are stable at the falling edge; a handshake seen here
  // completes on the next rising edge.
  always @(negedge ACLK) begin
    beat_t e;
    if (!ARESETn) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("beat", {out_data, out_strb, out_keep, out_last, out_id, out_dest, out_user},
                {e.data, e.strb, e.keep, e.last, e.id, e.dest, e.user});
          if (chk_lat) check("latency", 64'(cyc - e.cyc), 64'd1);
        end
      end
      if (TVALID && TREADY) begin
        e.data = TDATA; e.strb = TSTRB; e.keep = TKEEP; e.last = TLAST;
        e.id = TID; e.dest = TDEST; e.user = TUSER; e.cyc = cyc;
        sb.push_back(e);
      end
    end
  end

  // --------------------------------------------------------------- driver
  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic [3:0] s,
                           input logic l, input logic [7:0] id, input logic [3:0] dst,
                           input logic clr);
    int waits = 0;
    TVALID = 1'b1; TDATA = d; TKEEP = k; TSTRB = s; TLAST = l;
    TID = id; TDEST = dst; TUSER = 8'($urandom); clear_status = clr;
    while (!TREADY && waits < 100) begin
      @(posedge ACLK); #1;
      waits++;
    end
    if (!TREADY) check("send_timeout", 64'd0, 64'd1);
    else begin
      @(posedge ACLK); #1;
    end
    TVALID = 1'b0; clear_status = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tready"},     TREADY,         0);
    check({tag, "_out_valid"},  out_valid,      0);
    check({tag, "_fifo_level"}, fifo_level,     0);
    check({tag, "_pkt_count"},  pkt_count,      0);
    check({tag, "_last_bytes"}, last_pkt_bytes, 0);
    check({tag, "_errs"},       {err_sparse, err_keep_strb, err_interleave}, 0);
    check({tag, "_out_fields"}, {out_data, out_strb, out_keep, out_last, out_id, out_dest, out_user}, 0);
  endtask

  // --------------------------------------------------------------- vectors
  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic [3:0]  strb;
    logic        last;
    logic [7:0]  id;
    logic [3:0]  dest;
    logic        clr;
    logic [15:0] exp_pc;
    logic [15:0] exp_lb;
    logic [2:0]  exp_err;   // {sparse, keep_strb, interleave}
  } vec_t;

  vec_t vecs[10];

  initial begin
    int w;
    // basic 3-beat packet: 4+4+2 kept bytes
    vecs[0] = '{32'h11111111, 4'hF, 4'hF, 1'b0, 8'h01, 4'h0, 1'b0, 16'd0, 16'd0,  3'b000};
    vecs[1] = '{32'h22222222, 4'hF, 4'hF, 1'b0, 8'h01, 4'h0, 1'b0, 16'd0, 16'd0,  3'b000};
    vecs[2] = '{32'h00003333, 4'h3, 4'h3, 1'b1, 8'h01, 4'h0, 1'b0, 16'd1, 16'd10, 3'b000};
    // sparse non-last beat, then a strobe-outside-keep TLAST beat (3+2 bytes)
    vecs[3] = '{32'hAAAA0001, 4'h7, 4'h7, 1'b0, 8'h01, 4'h0, 1'b0, 16'd1, 16'd10, 3'b100};
    vecs[4] = '{32'hAAAA0002, 4'h3, 4'hF, 1'b1, 8'h01, 4'h0, 1'b0, 16'd2, 16'd5,  3'b110};
    // interleave: ID changes mid-packet
    vecs[5] = '{32'hBBBB0001, 4'hF, 4'hF, 1'b0, 8'h01, 4'h0, 1'b0, 16'd2, 16'd5,  3'b110};
    vecs[6] = '{32'hBBBB0002, 4'hF, 4'hF, 1'b1, 8'h02, 4'h0, 1'b0, 16'd3, 16'd8,  3'b111};
    // clear colliding with a TLAST beat, then with a sparse beat
    vecs[7] = '{32'hCCCC0001, 4'hF, 4'hF, 1'b1, 8'h01, 4'h0, 1'b1, 16'd1, 16'd4,  3'b000};
    vecs[8] = '{32'hCCCC0002, 4'h1, 4'h1, 1'b0, 8'h03, 4'h0, 1'b1, 16'd0, 16'd0,  3'b100};
    vecs[9] = '{32'hCCCC0003, 4'hF, 4'hF, 1'b1, 8'h03, 4'h0, 1'b0, 16'd1, 16'd5,  3'b100};

    ARESETn = 1'b0; TVALID = 1'b0; TDATA = '0; TSTRB = '0; TKEEP = '0; TLAST = 1'b0;
    TID = '0; TDEST = '0; TUSER = '0; out_ready = 1'b0; clear_status = 1'b0;

    // ---- reset state
    repeat (3) @(posedge ACLK);
    #1;
    check_reset_outputs("reset");
    ARESETn = 1'b1;
    @(posedge ACLK); #1;
    check("tready_after_reset", TREADY, 1);

    // ---- table-driven beats
    out_ready = 1'b1;
    chk_lat   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send_beat(vecs[i].data, vecs[i].keep, vecs[i].strb, vecs[i].last,
                vecs[i].id, vecs[i].dest, vecs[i].clr);
      check($sformatf("v%0d_pkt_count", i),  pkt_count,      vecs[i].exp_pc);
      check($sformatf("v%0d_last_bytes", i), last_pkt_bytes, vecs[i].exp_lb);
      check($sformatf("v%0d_errs", i), {err_sparse, err_keep_strb, err_interleave}, vecs[i].exp_err);
    end
    repeat (2) @(posedge ACLK);
    #1;
    check("drain_after_vectors", 64'(sb.size()), 0);

    // ---- backpressure: 10 beats into a depth-8 FIFO with out_ready low
    chk_lat   = 1'b0;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++)
          send_beat(32'hB0000000 + 32'(i), 4'hF, 4'hF, (i == 9), 8'h05, 4'h0, 1'b0);
      end
    join_none
    repeat (12) @(posedge ACLK);
    #1;
    check("bp_tready_full",  TREADY, 0);
    check("bp_level_full",   fifo_level, 8);
    check("bp_accepted",     64'(sb.size()), 8);
    out_ready = 1'b1;
    @(posedge ACLK); #1;
    check("bp_tready_after_pop", TREADY, 1);
    w = 0;
    while ((sb.size() != 0 || TVALID) && w < 100) begin
      @(posedge ACLK);
      w++;
    end
    wait fork;
    repeat (2) @(posedge ACLK);
    #1;
    check("bp_drained",    64'(sb.size()), 0);
    check("bp_level_end",  fifo_level, 0);
    check("bp_pkt_count",  pkt_count, 2);
    check("bp_last_bytes", last_pkt_bytes, 40);

    // ---- reset mid-packet: 2 of 4 beats parked in the FIFO
    out_ready = 1'b0;
    send_beat(32'hD0000001, 4'hF, 4'hF, 1'b0, 8'h06, 4'h0, 1'b0);
    send_beat(32'hD0000002, 4'hF, 4'hF, 1'b0, 8'h06, 4'h0, 1'b0);
    check("mid_level_before_reset", fifo_level, 2);
    ARESETn = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    @(posedge ACLK); #1;
    check("mid_tready_after_release", TREADY, 1);
    check("mid_no_stale",             out_valid, 0);
    out_ready = 1'b1;
    chk_lat   = 1'b1;
    send_beat(32'hC0FFEE00, 4'hF, 4'hF, 1'b1, 8'h07, 4'h0, 1'b0);
    check("mid_pkt_count",  pkt_count, 1);
    check("mid_last_bytes", last_pkt_bytes, 4);
    check("mid_errs", {err_sparse, err_keep_strb, err_interleave}, 0);
    repeat (3) @(posedge ACLK);
    #1;
    check("mid_drained",   64'(sb.size()), 0);
    check("mid_level_end", fifo_level, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/axis_stream_receiver.md
# axis_stream_receiver

Synthesizable AXI4-Stream slave that accepts packets on the T* interface, buffers them in a FIFO, and forwards them unchanged on a valid/ready output toward the I2S transmit datapath. It runs protocol checks on every accepted beat: keep/strobe consistency, sparse non-last beats, and ID/DEST interleaving. It also reports packet statistics. It is the receiving end of the streaming interface driven by the team's AXI4-Stream master BFM, and its checks match how that BFM builds packets: full beats, then a right-trimmed strobe/keep on the TLAST beat.

## Interface
Parameters:
- DATA_BUS_WIDTH, 32, TDATA width; must be 32 or 64.
- ID_BUS_WIDTH, 8, TID width.
- DEST_BUS_WIDTH, 4, TDEST width.
- USER_BUS_WIDTH, 8, TUSER width.
- FIFO_DEPTH, 8, number of buffered beats; a power of two, at least 2.
- STROBE_NOT_USED, 0, 1 disables err_keep_strb.
- KEEP_NOT_USED, 0, 1 treats every TKEEP as all-ones.

Ports (reset ARESETn, asynchronous, active-low; clock ACLK):
- ACLK  in  1  clock.
- ARESETn  in  1  asynchronous active-low reset.
- TVALID  in  1  upstream beat valid.
- TREADY  out  1  beat accepted when TVALID and TREADY are both high at a rising ACLK edge.
- TDATA  in  DATA_BUS_WIDTH  beat data.
- TSTRB, TKEEP  in  DATA_BUS_WIDTH/8 each  byte qualifiers.
- TLAST  in  1  last beat of packet.
- TID  in  ID_BUS_WIDTH  stream ID.
- TDEST  in  DEST_BUS_WIDTH  stream destination.
- TUSER  in  USER_BUS_WIDTH  sideband.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  downstream accept.
- out_data, out_strb, out_keep, out_last, out_id, out_dest, out_user  out  same widths as the T* inputs  FIFO head fields.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  beats currently stored.
- pkt_count  out  16  accepted TLAST beats, saturating at 0xFFFF.
- last_pkt_bytes  out  16  kept-byte total of the most recently completed packet, saturating.
- err_sparse, err_keep_strb, err_interleave  out  1 each  sticky error flags.
- clear_status  in  1  synchronous clear of pkt_count, last_pkt_bytes and the err_* flags.

## Operation
- **FIFO write.** An accepted beat pushes {TDATA, TSTRB, TKEEP, TLAST, TID, TDEST, TUSER} into the FIFO.
- **FIFO read.** The head is popped when out_valid and out_ready are both high. out_valid = (fifo_level != 0). Beats leave in acceptance order, bit-exact.
- **Simultaneous push and pop** leaves fifo_level unchanged. Push and pop pointers wrap modulo FIFO_DEPTH.
- **TREADY** is registered: TREADY_next = (level_next < FIFO_DEPTH). There is no full-bypass. While full, TREADY stays low even in a cycle where a pop occurs; it rises on the following edge.
- **Packet state machine:**
  - IDLE: an accepted beat latches TID/TDEST and goes to IN_PKT, unless TLAST is set, in which case it stays in IDLE.
  - IN_PKT: an accepted beat with TLAST returns to IDLE.
- **Byte accumulator.** Adds popcount(TKEEP) per accepted beat; all-ones when KEEP_NOT_USED. On a TLAST beat, the final sum (this beat included) loads last_pkt_bytes, and the accumulator clears.
- **Error checks** on accepted beats. A flag is set on the edge that accepts the offending beat, and the beat is still forwarded:
  - err_sparse: TLAST=0 and TKEEP != all-ones (skipped when KEEP_NOT_USED).
  - err_keep_strb: (TSTRB & ~TKEEP) != 0 (skipped when STROBE_NOT_USED or KEEP_NOT_USED).
  - err_interleave: state is IN_PKT and TID or TDEST differs from the latched values.
- **clear_status with a same-cycle event.** Clear applies first, then the event. A TLAST accepted in that cycle gives pkt_count=1. An error in that cycle leaves its flag set.

## Timing
- **Reset values:** TREADY=0, out_valid=0, fifo_level=0, pkt_count=0, last_pkt_bytes=0, all err_*=0, state IDLE, accumulator 0. out_* data fields are 0.
- **After reset release:** TREADY rises on the first ACLK rising edge after ARESETn deasserts.
- **Latency:** a beat accepted at edge k into an empty FIFO gives out_valid=1 after edge k, so it can be popped at edge k+1.
- **Throughput:** one beat per cycle sustained when out_ready=1.
- **Status timing:** pkt_count, last_pkt_bytes and the err_* flags update on the accepting edge.
- **Reset mid-packet:** the FIFO is flushed, the partial packet is discarded, and all outputs return to their reset values immediately (asynchronous).
- **TVALID low:** no state changes; TDATA and the other T* inputs are ignored.

## Test plan
- **Basic packet.** DATA_BUS_WIDTH=32, out_ready=1. Send 3 beats, TKEEP=TSTRB=F,F,3, TLAST on beat 3, data 0x11111111/0x22222222/0x00003333.
  - Required: the same 3 beats appear on out_*, each one cycle after acceptance.
  - Required: pkt_count=1, last_pkt_bytes=10, all err_*=0.
- **Backpressure.** out_ready=0, FIFO_DEPTH=8, TVALID held with 10 beats queued.
  - Required: 8 beats accepted, then TREADY=0 and fifo_level=8.
  - Then set out_ready=1. Required: TREADY returns to 1 one cycle after the first pop, all 10 beats exit in order, and fifo_level ends at 0.
- **Error flags.** Send separately:
  - A non-last beat with TKEEP=0x7. Required: err_sparse=1.
  - A beat with TSTRB=0xF, TKEEP=0x3. Required: err_keep_strb=1.
  - A 2-beat packet with TID 0x01 then 0x02. Required: err_interleave=1.
  - Required in every case: the flags stay set afterwards and the data is still forwarded.
- **Clear collision.** Pulse clear_status in the same cycle as an accepted TLAST beat.
  - Required: pkt_count=1, and the other error flags are cleared.
- **Reset mid-packet.** Assert ARESETn low after 2 of 4 beats, then release and send a fresh 1-beat packet with TKEEP=0xF.
  - Required: all outputs read reset values during reset, no stale beats appear on out_*, and pkt_count=1, last_pkt_bytes=4.
